// File: rtl/ehl_gpio_arbiter.sv
// ehl_gpio_arbiter
// ----------------
// Two bus requesters share the single GPIO register-access port: requester 0
// is normally the CPU slave port and requester 1 the debug/DMA port.
// Arbitration is round-robin. A requester can keep ownership across accesses
// with its lock input, so that a read-modify-write on one GPIO register is not
// interleaved with the other requester. A held lock expires after LOCK_TMO
// idle cycles in which its owner does not request (LOCK_TMO = 0 never expires).
//
// Each access runs IDLE -> ACCESS -> RESP -> IDLE:
//   IDLE   : pick a winner and capture its we/addr/wdata
//   ACCESS : one-cycle gpio_wr or gpio_rd strobe to the decoder
//   RESP   : owner's ack pulses, read data is returned, lock and pointer updated
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   req0/req1           access request, held with its fields until ack
//   we0/we1             1 = write, 0 = read
//   lock0/lock1         keep ownership after this access
//   addr0/addr1         6-bit GPIO address {reg[3:0], op[1:0]}
//   wdata0/wdata1       write data
//   ack0/ack1           one-cycle completion pulse
//   rdata0/rdata1       read data, valid with ack and held until that port's next ack
//   gpio_wr/gpio_rd     strobes to the decoder, only ever asserted in ACCESS
//   gpio_addr/gpio_wdata address and data to the decoder, hold their last value
//   gpio_rdata          register-file read mux, valid the cycle after gpio_rd
//   grant               one-hot current owner, 0 when idle
//   locked              lock currently held
module ehl_gpio_arbiter #(
    parameter int WIDTH    = 32,
    parameter int LOCK_TMO = 15,
    parameter int TMO_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [5:0]       addr0,
    input  logic [5:0]       addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             gpio_wr,
    output logic             gpio_rd,
    output logic [5:0]       gpio_addr,
    output logic [WIDTH-1:0] gpio_wdata,
    input  logic [WIDTH-1:0] gpio_rdata,
    output logic [1:0]       grant,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic             TMO_ON    = (LOCK_TMO != 0);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(LOCK_TMO);

    state_t             state;
    state_t             state_nxt;

    // Captured request of the current owner
    logic               owner;
    logic               cur_we;
    logic [5:0]         cur_addr;
    logic [WIDTH-1:0]   cur_wdata;

    // Lock, timeout and round-robin bookkeeping
    logic               lock_held;
    logic               lock_owner;
    logic               last_owner;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [WIDTH-1:0]   rdata0_q;
    logic [WIDTH-1:0]   rdata1_q;

    logic               win;
    logic               win_id;
    logic               owner_req;
    logic               tmo_expire;

    // Arbitration and next state. A lock that expires in this cycle no longer
    // restricts eligibility, so the other requester can win in the same cycle.
    always_comb begin
        state_nxt  = state;
        win        = 1'b0;
        win_id     = 1'b0;
        owner_req  = lock_owner ? req1 : req0;
        tmo_expire = (state == IDLE) && TMO_ON && lock_held && !owner_req &&
                     (tmo_cnt == TMO_LIMIT);
        case (state)
            IDLE: begin
                if (lock_held && !tmo_expire) begin
                    win    = owner_req;
                    win_id = lock_owner;
                end else if (req0 && req1) begin
                    win    = 1'b1;
                    win_id = !last_owner;
                end else if (req0 || req1) begin
                    win    = 1'b1;
                    win_id = req1;
                end
                if (win) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset mid-access drops the strobe and loses the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winner's request fields. These also drive gpio_addr and
    // gpio_wdata directly, which is why those outputs hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= 1'b0;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else if (state == IDLE && win) begin
            owner     <= win_id;
            cur_we    <= win_id ? we1 : we0;
            cur_addr  <= win_id ? addr1 : addr0;
            cur_wdata <= win_id ? wdata1 : wdata0;
        end
    end

    // Lock and timeout. While locked in IDLE without a win the owner is by
    // construction not requesting, so every such cycle counts towards expiry.
    // RESP refreshes the lock from the owner's lock input and moves the
    // round-robin pointer; last_owner starts at 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_held  <= 1'b0;
            lock_owner <= 1'b0;
            last_owner <= 1'b1;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tmo_expire) begin
                        lock_held <= 1'b0;
                    end
                    if (win || tmo_expire) begin
                        tmo_cnt <= '0;
                    end else if (TMO_ON && lock_held) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RESP: begin
                    lock_held  <= owner ? lock1 : lock0;
                    lock_owner <= owner;
                    last_owner <= owner;
                end
                default: begin
                end
            endcase
        end
    end

    // Read-data holding registers, loaded at the end of a read's RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state == RESP && !cur_we) begin
            if (owner) begin
                rdata1_q <= gpio_rdata;
            end else begin
                rdata0_q <= gpio_rdata;
            end
        end
    end

    // gpio_rdata is only valid during RESP, so a read bypasses it straight to
    // the owner's rdata while ack is high; afterwards the holding register
    // keeps presenting the same value.
    always_comb begin
        gpio_wr    = (state == ACCESS) && cur_we;
        gpio_rd    = (state == ACCESS) && !cur_we;
        gpio_addr  = cur_addr;
        gpio_wdata = cur_wdata;
        ack0       = (state == RESP) && !owner;
        ack1       = (state == RESP) && owner;
        rdata0     = (ack0 && !cur_we) ? gpio_rdata : rdata0_q;
        rdata1     = (ack1 && !cur_we) ? gpio_rdata : rdata1_q;
        grant      = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
        locked     = lock_held;
    end

endmodule
